// File: rtl/tt_defs.sv
// rtl/tt_defs.sv - shared state encodings and default widths for the sweep checker
package tt_defs;

  localparam int N_IN_DEF  = 2;
  localparam int ERR_W_DEF = 4;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tt_settle_timer.sv
// rtl/tt_settle_timer.sv - loadable down-counter that times how long each vector is held
module tt_settle_timer
  import tt_defs::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/tt_sweep_checker.sv
// rtl/tt_sweep_checker.sv - truth-table sweeper comparing two combinational implementations
module tt_sweep_checker
  import tt_defs::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = 1,
  parameter int ERR_W  = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  output logic [N_IN-1:0]  vec_out,
  input  logic             res_a,
  input  logic             res_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N_IN-1:0]  first_err_vec,
  output logic             first_err_valid
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_start_acc;
  logic             w_sample;
  logic             w_last;
  logic             w_zero;
  logic             w_load;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_nxt;

  logic [N_IN-1:0]  r_vec;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err_cnt;
  logic [N_IN-1:0]  r_first_vec;
  logic             r_first_valid;

  assign w_last     = &r_vec;
  assign w_mismatch = res_a ^ res_b;
  assign w_load     = w_start_acc | (w_sample & ~w_last);

  // Saturating increment: the all-ones count absorbs further mismatches.
  assign w_err_nxt = (w_sample && w_mismatch && (r_err_cnt != '1))
                   ? r_err_cnt + ERR_W'(1) : r_err_cnt;

  tt_settle_timer u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (w_load),
    .load_val (CNT_W'(SETTLE)),
    .zero     (w_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the start-accept and sample strobes; start is ignored while sweeping.
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_WAIT;
          w_start_acc = 1'b1;
        end
      end
      ST_WAIT: begin
        if (w_zero) begin
          w_sample = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Vector counter and mismatch recording; pass uses the count including the last compare.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vec         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_err_cnt     <= '0;
      r_first_vec   <= '0;
      r_first_valid <= 1'b0;
    end else if (w_start_acc) begin
      r_vec         <= '0;
      r_busy        <= 1'b1;
      r_done        <= 1'b0;
      r_err_cnt     <= '0;
      r_first_vec   <= '0;
      r_first_valid <= 1'b0;
    end else if (w_sample) begin
      r_err_cnt <= w_err_nxt;
      if (w_mismatch && !r_first_valid) begin
        r_first_vec   <= r_vec;
        r_first_valid <= 1'b1;
      end
      if (w_last) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_pass <= (w_err_nxt == '0);
      end else begin
        r_vec <= r_vec + N_IN'(1);
      end
    end
  end

  assign vec_out         = r_vec;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_cnt         = r_err_cnt;
  assign first_err_vec   = r_first_vec;
  assign first_err_valid = r_first_valid;

endmodule
